// File: rtl/alu_pkg.sv
// Shared ALU execute-path types and sizing for the pipelined CLA add/sub unit.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int GROUP_W = 4;
  localparam int NGRP    = XLEN / GROUP_W;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  typedef grp_pg_t [NGRP-1:0] grp_pg_vec_t;

endpackage

// File: rtl/cla_4bit_adder.sv
// 4-bit carry-lookahead adder slice: local sum plus group propagate/generate.
module cla_4bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       p,
  output logic       g
);

  logic [3:0] pp;
  logic [3:0] gg;
  logic [3:0] c;

  assign pp = a ^ b;
  assign gg = a & b;

  assign c[0] = cin;
  assign c[1] = gg[0] | (pp[0] & cin);
  assign c[2] = gg[1] | (pp[1] & gg[0])
              | (pp[1] & pp[0] & cin);
  assign c[3] = gg[2] | (pp[2] & gg[1])
              | (pp[2] & pp[1] & gg[0])
              | (pp[2] & pp[1] & pp[0] & cin);

  assign sum = pp ^ c;

  assign p = &pp;
  assign g = gg[3] | (pp[3] & gg[2])
           | (pp[3] & pp[2] & gg[1])
           | (pp[3] & pp[2] & pp[1] & gg[0]);

endmodule

// File: rtl/lookahead_carry_unit.sv
// Second-level lookahead: all group carries as flat sum-of-products of P/G/cin.
module lookahead_carry_unit
  import alu_pkg::*;
(
  input  logic [NGRP-1:0] p,
  input  logic [NGRP-1:0] g,
  input  logic            cin,
  output logic [NGRP:0]   c
);

  logic term;
  logic acc;

  // c[i+1] = |(g[j] & p[j+1..i]) | (p[0..i] & cin), no rippling
  always_comb begin
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < NGRP; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++)
        term = term & p[j];
      acc = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++)
          term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

endmodule

// File: rtl/cla_addsub_pipe32.sv
// Two-stage pipelined 32-bit CLA add/sub with valid/ready on both sides.
// Define ADDER_FLAGS_EN to build the registered overflow/zero flags.
module cla_addsub_pipe32
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            carry_out,
  output logic            overflow,
  output logic            zero
);

  logic            s1_valid;
  logic            s2_valid;
  logic            s1_adv;
  logic            s2_adv;

  logic [XLEN-1:0] b_eff;
  grp_pg_vec_t     pg;
  logic [NGRP-1:0] grp_p;
  logic [NGRP-1:0] grp_g;
  logic [NGRP:0]   c;
  logic [XLEN-1:0] unused_s1_sum;

  logic [XLEN-1:0] s1_a;
  logic [XLEN-1:0] s1_b;
  logic [NGRP:0]   s1_c;
  logic [XLEN-1:0] sum;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  assign b_eff = sub ? ~b : b;

  // Stage 1: group P/G only; the local sums are recomputed later
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_s1
    cla_4bit_adder u_pg (
      .a   (a[gi*GROUP_W +: GROUP_W]),
      .b   (b_eff[gi*GROUP_W +: GROUP_W]),
      .cin (1'b0),
      .sum (unused_s1_sum[gi*GROUP_W +: GROUP_W]),
      .p   (pg[gi].p),
      .g   (pg[gi].g)
    );
    assign grp_p[gi] = pg[gi].p;
    assign grp_g[gi] = pg[gi].g;
  end

  lookahead_carry_unit u_lcu (
    .p   (grp_p),
    .g   (grp_g),
    .cin (sub),
    .c   (c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= a;
        s1_b <= b_eff;
        s1_c <= c;
      end
    end
  end

  // Stage 2: re-add each group with its resolved carry-in
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_s2
    cla_4bit_adder u_sum (
      .a   (s1_a[gi*GROUP_W +: GROUP_W]),
      .b   (s1_b[gi*GROUP_W +: GROUP_W]),
      .cin (s1_c[gi]),
      .sum (sum[gi*GROUP_W +: GROUP_W]),
      .p   (),
      .g   ()
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result    <= sum;
        carry_out <= s1_c[NGRP];
      end
    end
  end

`ifdef ADDER_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      overflow <= (s1_a[XLEN-1] == s1_b[XLEN-1])
                & (sum[XLEN-1] != s1_a[XLEN-1]);
      zero     <= ~|sum;
    end
  end
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule
